// File: rtl/jpeg_seq_pkg.sv
// Purpose : shared types and sizing for the JPEG block sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a. Contents: FSM state enum, block geometry, counter widths.
package jpeg_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_BULK,
    S_LOAD_PIX,
    S_DCT_GO,
    S_DCT_WAIT,
    S_QUANT,
    S_ZZ_GO,
    S_HUFF_GO,
    S_HUFF_WAIT,
    S_DONE
  } seq_state_t;

  localparam int ROWS      = 8;
  localparam int BLOCK_PIX = 64;
  localparam int PIX_W     = $clog2(BLOCK_PIX);
  localparam int ROW_W     = $clog2(ROWS);
  // Delay counter must hold DCT_LAT-1 for DCT_LAT up to 255.
  localparam int CNT_W     = 8;

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(BLOCK_PIX - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

endpackage

// File: rtl/jpeg_block_sequencer_delay.sv
// Purpose : loadable down-counter with terminal-count flags (current and next cycle).
// Latency : load/decrement take effect at the next clock edge; tc_next is combinational.
// Backpressure: none. Ports: clock, reset_n, load, load_val, dec in; tc, tc_next out.
module seq_delay_counter
  import jpeg_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc,
  output logic         tc_next
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_nxt;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    count_nxt = count_q;
    if (load) begin
      count_nxt = load_val;
    end else if (dec && (count_q != '0)) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // tc_next lets the owner register strobes that coincide with terminal count.
  assign tc      = (count_q == '0);
  assign tc_next = (count_nxt == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Purpose : sequences one 8x8 block through load -> DCT -> quantize -> zigzag -> Huffman.
// Latency : bulk block = 2 + DCT_LAT + 8*(QUANT_LAT+1) + 3 cycles + Huffman wait, registered strobes.
// Backpressure: pix_ready high only while streaming pixels; huff_done gates completion.
// Ports: clock/reset_n; blk_start, load_mode, is_luminance_in, pix_valid, huff_done, abort in;
//        busy, blk_done, pix_ready, datapath strobes, matrix_row, is_luminance out.
module jpeg_block_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int DCT_LAT   = 12,
  parameter int QUANT_LAT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       blk_start,
  input  logic       load_mode,
  input  logic       is_luminance_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       huff_done,
  input  logic       abort,
  output logic       busy,
  output logic       blk_done,
  output logic       input_enable,
  output logic       input_1pix_enable,
  output logic       dct_enable,
  output logic       dct_end_enable,
  output logic       zigzag_input_enable,
  output logic       zigag_enable,
  output logic [7:0] matrix_row,
  output logic       Huffman_start,
  output logic       is_luminance
);

  localparam logic [CNT_W-1:0] DCT_LOAD   = CNT_W'(DCT_LAT - 1);
  localparam logic [CNT_W-1:0] QUANT_LOAD = CNT_W'(QUANT_LAT);

  seq_state_t       state_q, state_nxt;
  logic [ROW_W-1:0] row_q, row_nxt;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_nxt;
  logic             lum_nxt;

  logic             ctr_load;
  logic             ctr_dec;
  logic [CNT_W-1:0] ctr_val;
  logic             ctr_tc;
  logic             ctr_tc_next;

  // One counter times both the DCT wait and each quantize row.
  seq_delay_counter #(.W(CNT_W)) u_delay (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .tc       (ctr_tc),
    .tc_next  (ctr_tc_next)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      row_q     <= row_nxt;
      pix_cnt_q <= pix_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    row_nxt     = row_q;
    pix_cnt_nxt = pix_cnt_q;
    lum_nxt     = is_luminance;
    ctr_load    = 1'b0;
    ctr_dec     = 1'b0;
    ctr_val     = '0;

    case (state_q)
      S_IDLE: begin
        if (blk_start) begin
          lum_nxt   = is_luminance_in;
          state_nxt = load_mode ? S_LOAD_PIX : S_LOAD_BULK;
        end
      end
      S_LOAD_BULK: state_nxt = S_DCT_GO;
      S_LOAD_PIX: begin
        // pix_ready is high throughout this state, so pix_valid alone is an accept.
        if (pix_valid) begin
          if (pix_cnt_q == LAST_PIX) begin
            state_nxt   = S_DCT_GO;
            pix_cnt_nxt = '0;
          end else begin
            pix_cnt_nxt = pix_cnt_q + 1'b1;
          end
        end
      end
      S_DCT_GO: begin
        ctr_load  = 1'b1;
        ctr_val   = DCT_LOAD;
        state_nxt = S_DCT_WAIT;
      end
      S_DCT_WAIT: begin
        if (ctr_tc) begin
          state_nxt = S_QUANT;
          row_nxt   = '0;
          ctr_load  = 1'b1;
          ctr_val   = QUANT_LOAD;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_QUANT: begin
        if (ctr_tc) begin
          if (row_q == LAST_ROW) begin
            state_nxt = S_ZZ_GO;
            row_nxt   = '0;
          end else begin
            row_nxt  = row_q + 1'b1;
            ctr_load = 1'b1;
            ctr_val  = QUANT_LOAD;
          end
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_ZZ_GO:     state_nxt = S_HUFF_GO;
      S_HUFF_GO:   state_nxt = S_HUFF_WAIT;
      S_HUFF_WAIT: if (huff_done) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase

    // Abort overrides every transition, including huff_done.
    if (abort && (state_q != S_IDLE)) begin
      state_nxt   = S_IDLE;
      row_nxt     = '0;
      pix_cnt_nxt = '0;
      ctr_load    = 1'b0;
      ctr_dec     = 1'b0;
    end
  end

  // Outputs are flops loaded from the next state, so each strobe lines up
  // with the state it belongs to. Timed strobes use the counter's lookahead.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy                <= 1'b0;
      blk_done            <= 1'b0;
      pix_ready           <= 1'b0;
      input_enable        <= 1'b0;
      dct_enable          <= 1'b0;
      dct_end_enable      <= 1'b0;
      zigzag_input_enable <= 1'b0;
      zigag_enable        <= 1'b0;
      Huffman_start       <= 1'b0;
      matrix_row          <= '0;
      is_luminance        <= 1'b0;
    end else begin
      busy                <= (state_nxt != S_IDLE);
      blk_done            <= (state_nxt == S_DONE);
      pix_ready           <= (state_nxt == S_LOAD_PIX);
      input_enable        <= (state_nxt == S_LOAD_BULK);
      dct_enable          <= (state_nxt == S_DCT_GO);
      dct_end_enable      <= (state_nxt == S_DCT_WAIT) && ctr_tc_next;
      zigzag_input_enable <= (state_nxt == S_QUANT) && ctr_tc_next;
      zigag_enable        <= (state_nxt == S_ZZ_GO);
      Huffman_start       <= (state_nxt == S_HUFF_GO);
      matrix_row          <= (state_nxt == S_QUANT) ? 8'(row_nxt) : 8'd0;
      is_luminance        <= lum_nxt;
    end
  end

  assign input_1pix_enable = pix_valid & pix_ready;

endmodule
